// File: rtl/sd_resp_ctrl_pkg.sv
// Shared definitions for the SPI-mode SD response receiver: response type codes,
// FSM state encoding and default timing limits.
package sd_resp_ctrl_pkg;

    typedef enum logic [1:0] {
        RESP_R1  = 2'd0,
        RESP_R1B = 2'd1,
        RESP_R3  = 2'd2,
        RESP_R7  = 2'd3
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_SHIFT_R1   = 3'd2,
        ST_SHIFT_EXT  = 3'd3,
        ST_BUSY       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam int NCR_MAX_BITS_DEF = 64;
    localparam int BUSY_MAX_DEF     = 65535;
    localparam int BUSY_CNT_W_DEF   = 16;

    // R3 and R7 carry a 32-bit trailer after the R1 byte
    function automatic logic is_ext(input resp_type_t t);
        return (t == RESP_R3) || (t == RESP_R7);
    endfunction

endpackage

// File: rtl/sd_resp_ctrl_shift_rx.sv
// MSB-first receive shift register with clear, shift enable and a saturating
// down-counter; 'last' marks the final bit of the current field.
module sd_resp_ctrl_shift_rx #(
    parameter int             W         = 8,
    parameter int             CNT_W     = 5,
    parameter logic [W-1:0]   CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             load_cnt,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             din,
    output logic [W-1:0]     data,
    output logic             last
);

    logic [W-1:0]     data_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= CLEAR_VAL;
            cnt_reg  <= '0;
        end else if (clear) begin
            data_reg <= CLEAR_VAL;
            cnt_reg  <= '0;
        end else begin
            if (shift_en)
                data_reg <= {data_reg[W-2:0], din};
            // a load wins over the decrement so the start bit can shift and arm the count together
            if (load_cnt)
                cnt_reg <= cnt_val;
            else if (shift_en && (cnt_reg != '0))
                cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign data = data_reg;
    assign last = (cnt_reg == '0);

endmodule

// File: rtl/sd_resp_ctrl.sv
// SD SPI-mode response receiver: hunts the start bit within the NCR window, captures R1,
// then the R3/R7 trailer or the R1b busy phase, and reports done/timeout over a 4-phase handshake.
module sd_resp_ctrl
    import sd_resp_ctrl_pkg::*;
#(
    parameter int NCR_MAX_BITS = NCR_MAX_BITS_DEF,
    parameter int BUSY_MAX     = BUSY_MAX_DEF,
    parameter int BUSY_CNT_W   = BUSY_CNT_W_DEF
) (
    input  logic        spiClock,
    input  logic        nReset,
    input  logic        req,
    input  logic [1:0]  respType,
    input  logic        miso,
    output logic        rxEnable,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] payload
);

    localparam int NCR_CNT_W = $clog2(NCR_MAX_BITS + 1);

    state_t                state_reg, state_next;
    resp_type_t            resp_type_reg;
    logic [NCR_CNT_W-1:0]  ncr_cnt_reg;
    logic [BUSY_CNT_W-1:0] busy_cnt_reg;
    logic                  timeout_reg;

    logic accept, ncr_expire, busy_expire, r1_last, pl_last;
    logic r1_shift, r1_load_cnt, pl_shift, pl_load_cnt, busy_enter;

    assign accept      = (state_reg == ST_IDLE) && req;
    assign ncr_expire  = miso && (ncr_cnt_reg == NCR_CNT_W'(NCR_MAX_BITS - 1));
    assign busy_expire = !miso && (busy_cnt_reg == BUSY_CNT_W'(BUSY_MAX - 1));

    always_ff @(posedge spiClock or negedge nReset) begin
        if (!nReset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // dropping req in any receiving state aborts straight back to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (req) state_next = ST_WAIT_START;
            ST_WAIT_START: begin
                if (!req)            state_next = ST_IDLE;
                else if (!miso)      state_next = ST_SHIFT_R1;
                else if (ncr_expire) state_next = ST_DONE;
            end
            ST_SHIFT_R1: begin
                if (!req)
                    state_next = ST_IDLE;
                else if (r1_last) begin
                    if (resp_type_reg == RESP_R1)       state_next = ST_DONE;
                    else if (resp_type_reg == RESP_R1B) state_next = ST_BUSY;
                    else                                state_next = ST_SHIFT_EXT;
                end
            end
            ST_SHIFT_EXT: begin
                if (!req)         state_next = ST_IDLE;
                else if (pl_last) state_next = ST_DONE;
            end
            ST_BUSY: begin
                if (!req)                     state_next = ST_IDLE;
                else if (miso || busy_expire) state_next = ST_DONE;
            end
            ST_DONE:       if (!req) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rxEnable    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
        done        = (state_reg == ST_DONE);
        r1_load_cnt = req && (state_reg == ST_WAIT_START) && !miso;
        r1_shift    = r1_load_cnt || (req && (state_reg == ST_SHIFT_R1));
        pl_load_cnt = req && (state_reg == ST_SHIFT_R1) && r1_last && is_ext(resp_type_reg);
        pl_shift    = req && (state_reg == ST_SHIFT_EXT);
        busy_enter  = req && (state_reg == ST_SHIFT_R1) && r1_last && (resp_type_reg == RESP_R1B);
    end

    always_ff @(posedge spiClock or negedge nReset) begin
        if (!nReset) begin
            resp_type_reg <= RESP_R1;
            ncr_cnt_reg   <= '0;
            busy_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            if (accept) begin
                resp_type_reg <= resp_type_t'(respType);
                ncr_cnt_reg   <= '0;
                timeout_reg   <= 1'b0;
            end
            if (req && (state_reg == ST_WAIT_START) && miso) begin
                if (ncr_expire)
                    timeout_reg <= 1'b1;
                else if (ncr_cnt_reg != '1)
                    ncr_cnt_reg <= ncr_cnt_reg + NCR_CNT_W'(1);
            end
            if (busy_enter)
                busy_cnt_reg <= '0;
            if (req && (state_reg == ST_BUSY) && !miso) begin
                if (busy_expire)
                    timeout_reg <= 1'b1;
                else if (busy_cnt_reg != '1)
                    busy_cnt_reg <= busy_cnt_reg + BUSY_CNT_W'(1);
            end
        end
    end

    assign timeout = timeout_reg;

    // the start bit (0) is shifted in first, so it ends up as r1[7]
    sd_resp_ctrl_shift_rx #(.W(8), .CNT_W(5), .CLEAR_VAL(8'hFF)) u_r1_rx (
        .clk      (spiClock),
        .rst_n    (nReset),
        .clear    (accept),
        .shift_en (r1_shift),
        .load_cnt (r1_load_cnt),
        .cnt_val  (5'd6),
        .din      (miso),
        .data     (r1),
        .last     (r1_last)
    );

    sd_resp_ctrl_shift_rx #(.W(32), .CNT_W(5), .CLEAR_VAL(32'h0)) u_payload_rx (
        .clk      (spiClock),
        .rst_n    (nReset),
        .clear    (accept),
        .shift_en (pl_shift),
        .load_cnt (pl_load_cnt),
        .cnt_val  (5'd31),
        .din      (miso),
        .data     (payload),
        .last     (pl_last)
    );

endmodule
